// File: rtl/hps_pixel_stream_src.sv
`default_nettype none
// ============================================================================
// Module   : hps_pixel_stream_src
// Purpose  : Captures HPS-written RGB pixels (one per write-toggle edge) into
//            a small show-ahead FIFO and replays them as an Avalon-ST video
//            stream tagged with start/end-of-frame markers.
// Ports    : clk, reset (async, active-high)
//            r_in/g_in/b_in  - 10-bit colour values from PIO out_ports
//            wr_toggle       - each edge (rise or fall) captures one pixel
//            clear           - synchronous soft clear, level-sensitive
//            src_*           - Avalon-ST source {R,G,B}, valid/ready, sop/eop
//            fifo_level      - registered FIFO occupancy (0..FIFO_DEPTH)
//            overflow        - sticky dropped-pixel flag
//            frame_count     - completed frames, wrapping 16-bit counter
// Revision : 1.0 - initial release
// ============================================================================
module hps_pixel_stream_src #(
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       r_in,
    input  logic [9:0]       g_in,
    input  logic [9:0]       b_in,
    input  logic             wr_toggle,
    input  logic             clear,
    output logic [29:0]      src_data,
    output logic             src_valid,
    input  logic             src_ready,
    output logic             src_sop,
    output logic             src_eop,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic [15:0]      frame_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int X_W   = $clog2(FRAME_W);
    localparam int Y_W   = $clog2(FRAME_H);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(FRAME_H - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [29:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             tog_q;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      frame_q, frame_d;

    logic w_cap;
    logic w_pop;
    logic w_full;
    logic w_wr_en;
    logic w_x_last;
    logic w_y_last;

    // ------------------------------------------------------------------------
    // Capture / pop decode. Clear suppresses both capture and pop so that a
    // toggle during clear is discarded and no pixel is counted.
    // ------------------------------------------------------------------------
    assign w_full   = (level_q == LVL_FULL);
    assign w_cap    = (wr_toggle != tog_q) & ~clear;
    assign w_pop    = src_valid & src_ready & ~clear;
    // A capture into a full FIFO still succeeds when a pop frees a slot.
    assign w_wr_en  = w_cap & (~w_full | w_pop);
    assign w_x_last = (x_q == X_LAST);
    assign w_y_last = (y_q == Y_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        x_d      = x_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        frame_d  = frame_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            x_d      = '0;
            y_d      = '0;
            ovf_d    = 1'b0;
        end else begin
            if (w_wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_cap & w_full & ~w_pop) begin
                ovf_d = 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                // Raster order: x fastest, frame completes on the eop pixel.
                if (w_x_last) begin
                    x_d = '0;
                    if (w_y_last) begin
                        y_d     = '0;
                        frame_d = frame_q + 16'd1;
                    end else begin
                        y_d = y_q + Y_W'(1);
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            level_d = level_q + {{(LVL_W-1){1'b0}}, w_wr_en}
                              - {{(LVL_W-1){1'b0}}, w_pop};
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tog_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tog_q    <= wr_toggle;
            x_q      <= x_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            frame_q  <= frame_d;
        end
    end

    // Storage needs no reset: contents are only visible while level != 0.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= {r_in, g_in, b_in};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign src_valid   = (level_q != '0);
    assign src_data    = src_valid ? mem_q[rd_ptr_q] : 30'd0;
    assign src_sop     = src_valid & (x_q == '0) & (y_q == '0);
    assign src_eop     = src_valid & w_x_last & w_y_last;
    assign fifo_level  = level_q;
    assign overflow    = ovf_q;
    assign frame_count = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_hps_pixel_stream_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_pixel_stream_src
// Purpose  : Self-checking bench for hps_pixel_stream_src (4x2 frame, 8-deep
//            FIFO). A queue-based reference model predicts the stream; a
//            negedge monitor compares every presented pixel against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_pixel_stream_src;

    localparam int FW    = 4;
    localparam int FH    = 2;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int NPIX  = FW * FH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [9:0]    r_in = '0, g_in = '0, b_in = '0;
    logic          wr_toggle = 1'b0;
    logic          clear = 1'b0;
    logic [29:0]   src_data;
    logic          src_valid;
    logic          src_ready = 1'b0;
    logic          src_sop;
    logic          src_eop;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [15:0]   frame_count;

    hps_pixel_stream_src #(
        .FRAME_W(FW), .FRAME_H(FH), .FIFO_DEPTH(DEPTH), .LVL_W(LW)
    ) dut (
        .clk(clk), .reset(reset),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .wr_toggle(wr_toggle), .clear(clear),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_sop(src_sop), .src_eop(src_eop),
        .fifo_level(fifo_level), .overflow(overflow),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a queue of accepted pixels, each tagged at acceptance
    // with its position in the frame (pixels accepted since last clear/reset).
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [29:0] d;
        logic        sop;
        logic        eop;
    } pix_t;

    pix_t        sb[$];
    logic        tog_m   = 1'b0;
    bit          ovf_m   = 1'b0;
    int          idx_m   = 0;
    logic [15:0] frame_m = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sb.delete();
            tog_m   = 1'b0;
            ovf_m   = 1'b0;
            idx_m   = 0;
            frame_m = '0;
        end else begin
            bit changed, was_full, popped;
            changed = (wr_toggle != tog_m);
            tog_m   = wr_toggle;
            if (clear) begin
                sb.delete();
                ovf_m = 1'b0;
                idx_m = 0;
            end else begin
                was_full = (sb.size() == DEPTH);
                popped   = (sb.size() != 0) && src_ready;
                if (popped) begin
                    if (sb[0].eop) frame_m = frame_m + 16'd1;
                    void'(sb.pop_front());
                end
                if (changed) begin
                    if (was_full && !popped) begin
                        ovf_m = 1'b1;
                    end else begin
                        sb.push_back('{d: {r_in, g_in, b_in},
                                       sop: (idx_m == 0),
                                       eop: (idx_m == NPIX - 1)});
                        idx_m = (idx_m + 1) % NPIX;
                    end
                end
            end
        end
    end

    // Monitor: whenever the DUT presents (or should present) a pixel, compare.
    always @(negedge clk) begin
        if (started && !reset) begin
            chk("valid", {31'd0, src_valid}, {31'd0, sb.size() != 0});
            chk("level", {28'd0, fifo_level}, sb.size());
            chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
            chk("frame_count", {16'd0, frame_count}, {16'd0, frame_m});
            if (src_valid && sb.size() != 0) begin
                chk("data", {2'd0, src_data}, {2'd0, sb[0].d});
                chk("sop", {31'd0, src_sop}, {31'd0, sb[0].sop});
                chk("eop", {31'd0, src_eop}, {31'd0, sb[0].eop});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic toggle_rand();
        r_in      = 10'($urandom_range(0, 1023));
        g_in      = 10'($urandom_range(0, 1023));
        b_in      = 10'($urandom_range(0, 1023));
        wr_toggle = ~wr_toggle;
    endtask

    logic [15:0] fc0;

    initial begin
        #1 reset = 1'b1;
        repeat (3) tick();
        reset   = 1'b0;
        started = 1'b1;
        tick();
        chk("rst_valid", {31'd0, src_valid}, 32'd0);
        chk("rst_level", {28'd0, fifo_level}, 32'd0);
        chk("rst_frame", {16'd0, frame_count}, 32'd0);
        chk("rst_data", {2'd0, src_data}, 32'd0);

        // Single pixel, one-cycle latency.
        src_ready = 1'b1;
        r_in = 10'h3FF; g_in = 10'h155; b_in = 10'h0AA;
        wr_toggle = 1'b1;
        tick();
        chk("p1_data", {2'd0, src_data}, 32'h3FF554AA);
        chk("p1_sop", {31'd0, src_sop}, 32'd1);
        chk("p1_level", {28'd0, fifo_level}, 32'd1);
        tick();
        chk("p1_level_after", {28'd0, fifo_level}, 32'd0);

        // Overflow: 10 captures into a stalled 8-deep FIFO.
        src_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            toggle_rand();
            tick();
        end
        chk("ovf_level", {28'd0, fifo_level}, 32'd8);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        src_ready = 1'b1;
        repeat (10) tick();
        chk("ovf_drained", {28'd0, fifo_level}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Two full frames back-to-back.
        fc0 = frame_count;
        for (int i = 0; i < 2 * NPIX; i++) begin
            toggle_rand();
            tick();
        end
        repeat (3) tick();
        chk("two_frames", {16'd0, frame_count}, {16'd0, fc0 + 16'd2});

        // Random backpressure with one capture every 4 cycles.
        for (int i = 0; i < 240; i++) begin
            src_ready = ($urandom_range(0, 1) == 1);
            if (i % 4 == 0) toggle_rand();
            tick();
        end
        src_ready = 1'b1;
        repeat (10) tick();

        // Clear mid-frame with buffered pixels and a simultaneous toggle.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            toggle_rand();
            tick();
        end
        tick();
        src_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            toggle_rand();
            tick();
        end
        chk("clr_pre_level", {28'd0, fifo_level}, 32'd3);
        fc0   = frame_count;
        clear = 1'b1;
        toggle_rand();
        tick();
        clear = 1'b0;
        chk("clr_level", {28'd0, fifo_level}, 32'd0);
        chk("clr_valid", {31'd0, src_valid}, 32'd0);
        tick();
        chk("clr_discard", {31'd0, src_valid}, 32'd0);
        chk("clr_frame", {16'd0, frame_count}, {16'd0, fc0});
        src_ready = 1'b1;
        toggle_rand();
        tick();
        chk("clr_next_sop", {31'd0, src_sop}, 32'd1);
        tick();

        // Asynchronous reset mid-frame with 4 buffered entries.
        src_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            toggle_rand();
            tick();
        end
        chk("arst_pre_level", {28'd0, fifo_level}, 32'd4);
        reset     = 1'b1;
        wr_toggle = 1'b0;
        #1;
        chk("arst_valid", {31'd0, src_valid}, 32'd0);
        chk("arst_level", {28'd0, fifo_level}, 32'd0);
        chk("arst_frame", {16'd0, frame_count}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        toggle_rand();
        tick();
        chk("arst_next_sop", {31'd0, src_sop}, 32'd1);
        src_ready = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
